// File: rtl/exp_sum_acc.sv
// Accumulates a vector of signed Q6.10 pow2 approximations into an unsigned
// saturating Q.10 sum, then holds the result until downstream consumes it.
module exp_sum_acc #(
   parameter int MAX_LEN = 64,
   parameter int SUM_W   = 20
) (
   input  logic                             i_clk,
   input  logic                             i_rst,
   input  logic                             i_en,
   input  logic                             i_valid,
   input  logic [15:0]                      i_data,
   input  logic                             i_last,
   output logic                             o_ready,
   output logic                             o_valid,
   input  logic                             i_ready,
   output logic [SUM_W-1:0]                 o_sum,
   output logic [$clog2(MAX_LEN+1)-1:0]     o_count,
   output logic                             o_ovf
);

   localparam int CNT_W = $clog2(MAX_LEN+1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ACCUM = 2'd1,
      HOLD  = 2'd2
   } state_t;

   state_t              r_state;
   logic                r_valid;
   logic [SUM_W-1:0]    r_sum;
   logic [CNT_W-1:0]    r_count;
   logic                r_ovf;

   logic [SUM_W:0]      w_elem;
   logic [SUM_W-1:0]    w_base;
   logic [SUM_W:0]      w_add;
   logic [SUM_W-1:0]    w_sum_next;
   logic [CNT_W-1:0]    w_count_next;
   logic                w_ovf_next;
   logic                w_end;

   // Negative approximations carry no probability mass, so they add zero.
   assign w_elem       = i_data[15] ? '0 : {{(SUM_W+1-15){1'b0}}, i_data[14:0]};
   assign w_base       = (r_state == IDLE) ? '0 : r_sum;
   assign w_add        = {1'b0, w_base} + w_elem;
   assign w_sum_next   = w_add[SUM_W] ? '1 : w_add[SUM_W-1:0];
   assign w_ovf_next   = ((r_state == ACCUM) & r_ovf) | w_add[SUM_W];
   assign w_count_next = (r_state == IDLE) ? CNT_W'(1) : r_count + CNT_W'(1);
   assign w_end        = i_last | (w_count_next == CNT_W'(MAX_LEN));

   assign o_ready = i_en & ~i_rst & (r_state != HOLD);
   assign o_valid = r_valid;
   assign o_sum   = r_sum;
   assign o_count = r_count;
   assign o_ovf   = r_ovf;

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_state <= IDLE;
         r_valid <= 1'b0;
         r_sum   <= '0;
         r_count <= '0;
         r_ovf   <= 1'b0;
      end else if (i_en) begin
         case (r_state)
            IDLE, ACCUM: begin
               if (i_valid) begin
                  r_sum   <= w_sum_next;
                  r_count <= w_count_next;
                  r_ovf   <= w_ovf_next;
                  r_state <= w_end ? HOLD : ACCUM;
                  r_valid <= w_end;
               end
            end
            HOLD: begin
               if (i_ready) begin
                  r_state <= IDLE;
                  r_valid <= 1'b0;
               end
            end
            default: begin
               r_state <= IDLE;
               r_valid <= 1'b0;
            end
         endcase
      end
   end

endmodule
